// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit:
// opcodes, functs, ALU control codes, mux selects and state encodings.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] BSEL_B    = 2'b00;
  localparam logic [1:0] BSEL_FOUR = 2'b01;
  localparam logic [1:0] BSEL_IMM  = 2'b10;
  localparam logic [1:0] BSEL_BR   = 2'b11;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// R-type funct to ALU control decoder.
// Unknown functs report funct_valid=0 and fall back to add.
module multicycle_control_alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_valid
);

  always_comb begin
    alu_control = ALU_ADD;
    funct_valid = 1'b1;
    unique case (1'b1)
      (funct == FN_ADD): alu_control = ALU_ADD;
      (funct == FN_SUB): alu_control = ALU_SUB;
      (funct == FN_AND): alu_control = ALU_AND;
      (funct == FN_OR):  alu_control = ALU_OR;
      (funct == FN_SLT): alu_control = ALU_SLT;
      default: begin
        alu_control = ALU_ADD;
        funct_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences shared ALU, memory,
// register file and PC muxes, stalling on the memory ready handshake.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       trap,
  output logic [3:0] state_out
);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] dec_alu;
  logic       funct_valid;

  multicycle_control_alu_decoder u_alu_dec (
    .funct       (funct),
    .alu_control (dec_alu),
    .funct_valid (funct_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    pc_source   = PCS_ALU;
    alu_src_a   = 1'b0;
    alu_src_b   = BSEL_B;
    alu_control = ALU_ADD;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    instr_done  = 1'b0;
    trap        = 1'b0;

    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = BSEL_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) begin
          state_nxt = S_DECODE;
        end
      end

      // Branch target is computed speculatively into ALUOut here.
      S_DECODE: begin
        alu_src_b = BSEL_BR;
        unique case (1'b1)
          (opcode == OP_RTYPE):
            state_nxt = S_EXEC;
          (opcode == OP_LW || opcode == OP_SW):
            state_nxt = S_MEMADR;
          (opcode == OP_BEQ):
            state_nxt = S_BRANCH;
          (opcode == OP_ADDI):
            state_nxt = S_ADDIEX;
          (opcode == OP_J):
            state_nxt = S_JUMP;
          default: begin
            if (TRAP_ON_ILLEGAL) begin
              state_nxt = S_TRAP;
            end else begin
              state_nxt  = S_FETCH;
              instr_done = 1'b1;
            end
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = BSEL_IMM;
        state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_nxt = S_MEMWB;
        end
      end

      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end

      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) begin
          state_nxt = S_FETCH;
        end
      end

      S_EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = dec_alu;
        if (funct_valid) begin
          state_nxt = S_ALUWB;
        end else if (TRAP_ON_ILLEGAL) begin
          state_nxt = S_TRAP;
        end else begin
          state_nxt  = S_FETCH;
          instr_done = 1'b1;
        end
      end

      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_source   = PCS_ALUOUT;
        pc_en       = zero;
        instr_done  = 1'b1;
        state_nxt   = S_FETCH;
      end

      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = BSEL_IMM;
        state_nxt = S_ADDIWB;
      end

      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end

      S_JUMP: begin
        pc_source  = PCS_JUMP;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end

      S_TRAP: begin
        trap      = 1'b1;
        state_nxt = S_TRAP;
      end

      default: begin
        state_nxt = S_FETCH;
      end
    endcase

    // Reset must silence every strobe in the same cycle it asserts.
    if (rst) begin
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      iord        = 1'b0;
      ir_write    = 1'b0;
      pc_en       = 1'b0;
      pc_source   = 2'b00;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_control = 3'b000;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      instr_done  = 1'b0;
      trap        = 1'b0;
    end
  end

  assign state_out = rst ? 4'd0 : state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: every output is packed
// into one vector and compared against hand-written expectations.
module tb_multicycle_control;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       pc_en;
  logic [1:0] pc_source;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       instr_done;
  logic       trap;
  logic [3:0] state_out;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_control #(.TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .iord        (iord),
    .ir_write    (ir_write),
    .pc_en       (pc_en),
    .pc_source   (pc_source),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .instr_done  (instr_done),
    .trap        (trap),
    .state_out   (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [21:0] obs;
  assign obs = {mem_read, mem_write, iord, ir_write, pc_en,
                pc_source, alu_src_a, alu_src_b, alu_control,
                reg_write, reg_dst, mem_to_reg, instr_done,
                trap, state_out};

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] ADDIEX = 4'd9;
  localparam logic [3:0] ADDIWB = 4'd10;
  localparam logic [3:0] JUMP   = 4'd11;
  localparam logic [3:0] TRAPST = 4'd12;

  // Args: state, mem_read, mem_write, iord, ir_write, pc_en,
  // pc_source, alu_src_a, alu_src_b, alu_control,
  // reg_write, reg_dst, mem_to_reg, instr_done, trap.
  function automatic logic [21:0] e(
    input logic [3:0] st,
    input logic mr, mw, io, irw, pce,
    input logic [1:0] pcs,
    input logic a,
    input logic [1:0] b,
    input logic [2:0] alu,
    input logic rw, rd, m2r, dn, tr
  );
    return {mr, mw, io, irw, pce, pcs, a, b, alu,
            rw, rd, m2r, dn, tr, st};
  endfunction

  function automatic logic [21:0] x_fetch(input logic r);
    return e(FETCH, 1, 0, 0, r, r, 2'b00, 0, 2'b01, 3'b010,
             0, 0, 0, 0, 0);
  endfunction

  function automatic logic [21:0] x_decode();
    return e(DECODE, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b010,
             0, 0, 0, 0, 0);
  endfunction

  function automatic logic [21:0] x_memadr();
    return e(MEMADR, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010,
             0, 0, 0, 0, 0);
  endfunction

  function automatic logic [21:0] x_exec(input logic [2:0] alu);
    return e(EXEC, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, alu,
             0, 0, 0, 0, 0);
  endfunction

  function automatic logic [21:0] x_aluwb();
    return e(ALUWB, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010,
             1, 1, 0, 1, 0);
  endfunction

  function automatic logic [21:0] x_trap();
    return e(TRAPST, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010,
             0, 0, 0, 0, 1);
  endfunction

  task automatic chk(input string tag, input logic [21:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then apply the inputs for the new state.
  task automatic cyc(input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic r);
    @(posedge clk);
    #1;
    opcode    = op;
    funct     = fn;
    zero      = z;
    mem_ready = r;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    opcode = 6'h00;
    funct = 6'h00;
    zero = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("reset_zero", 22'd0);

    // lw into MEMRD, then reset mid-instruction
    @(negedge clk);
    rst = 1'b0;
    opcode = 6'h23;
    mem_ready = 1'b1;
    #1;
    chk("first_fetch", x_fetch(1'b1));
    cyc(6'h23, 6'h00, 0, 1);
    chk("lw0_decode", x_decode());
    cyc(6'h23, 6'h00, 0, 1);
    chk("lw0_memadr", x_memadr());
    cyc(6'h23, 6'h00, 0, 0);
    chk("lw0_memrd", e(MEMRD, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00,
                       3'b010, 0, 0, 0, 0, 0));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_zero", 22'd0);
    @(negedge clk);
    rst = 1'b0;
    opcode = 6'h00;
    funct = 6'h20;
    mem_ready = 1'b1;
    #1;
    chk("post_rst_fetch", x_fetch(1'b1));

    // R-type add
    cyc(6'h00, 6'h20, 0, 1);
    chk("add_decode", x_decode());
    cyc(6'h00, 6'h20, 0, 1);
    chk("add_exec", x_exec(3'b010));
    cyc(6'h00, 6'h20, 0, 1);
    chk("add_aluwb", x_aluwb());

    // R-type sub and slt
    cyc(6'h00, 6'h22, 0, 1);
    chk("sub_fetch", x_fetch(1'b1));
    cyc(6'h00, 6'h22, 0, 1);
    chk("sub_decode", x_decode());
    cyc(6'h00, 6'h22, 0, 1);
    chk("sub_exec", x_exec(3'b110));
    cyc(6'h00, 6'h2A, 0, 1);
    chk("sub_aluwb", x_aluwb());
    cyc(6'h00, 6'h2A, 0, 1);
    chk("slt_fetch", x_fetch(1'b1));
    cyc(6'h00, 6'h2A, 0, 1);
    chk("slt_decode", x_decode());
    cyc(6'h00, 6'h2A, 0, 1);
    chk("slt_exec", x_exec(3'b111));
    cyc(6'h23, 6'h00, 0, 1);
    chk("slt_aluwb", x_aluwb());

    // lw with three stall cycles in MEMRD: 8 cycles total
    cyc(6'h23, 6'h00, 0, 1);
    chk("lw_fetch", x_fetch(1'b1));
    cyc(6'h23, 6'h00, 0, 1);
    chk("lw_decode", x_decode());
    cyc(6'h23, 6'h00, 0, 0);
    chk("lw_memadr", x_memadr());
    for (int i = 0; i < 4; i++) begin
      cyc(6'h23, 6'h00, 0, (i == 3));
      chk($sformatf("lw_memrd%0d", i),
          e(MEMRD, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b010,
            0, 0, 0, 0, 0));
    end
    cyc(6'h2B, 6'h00, 0, 1);
    chk("lw_memwb", e(MEMWB, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00,
                      3'b010, 1, 0, 1, 1, 0));

    // sw with one stall cycle
    cyc(6'h2B, 6'h00, 0, 1);
    chk("sw_fetch", x_fetch(1'b1));
    cyc(6'h2B, 6'h00, 0, 1);
    chk("sw_decode", x_decode());
    cyc(6'h2B, 6'h00, 0, 1);
    chk("sw_memadr", x_memadr());
    cyc(6'h2B, 6'h00, 0, 0);
    chk("sw_memwr_stall", e(MEMWR, 0, 1, 1, 0, 0, 2'b00, 0, 2'b00,
                            3'b010, 0, 0, 0, 0, 0));
    cyc(6'h04, 6'h00, 0, 1);
    chk("sw_memwr_done", e(MEMWR, 0, 1, 1, 0, 0, 2'b00, 0, 2'b00,
                           3'b010, 0, 0, 0, 1, 0));

    // beq taken, then not taken
    cyc(6'h04, 6'h00, 1, 1);
    chk("beq1_fetch", x_fetch(1'b1));
    cyc(6'h04, 6'h00, 1, 1);
    chk("beq1_decode", x_decode());
    cyc(6'h04, 6'h00, 1, 1);
    chk("beq1_branch", e(BRANCH, 0, 0, 0, 0, 1, 2'b01, 1, 2'b00,
                         3'b110, 0, 0, 0, 1, 0));
    cyc(6'h04, 6'h00, 0, 1);
    chk("beq0_fetch", x_fetch(1'b1));
    cyc(6'h04, 6'h00, 0, 1);
    chk("beq0_decode", x_decode());
    cyc(6'h04, 6'h00, 0, 0);
    chk("beq0_branch", e(BRANCH, 0, 0, 0, 0, 0, 2'b01, 1, 2'b00,
                         3'b110, 0, 0, 0, 1, 0));

    // FETCH stalled two cycles, then j
    cyc(6'h02, 6'h00, 0, 0);
    chk("jf_stall0", x_fetch(1'b0));
    cyc(6'h02, 6'h00, 0, 0);
    chk("jf_stall1", x_fetch(1'b0));
    cyc(6'h02, 6'h00, 0, 1);
    chk("jf_go", x_fetch(1'b1));
    cyc(6'h02, 6'h00, 0, 0);
    chk("j_decode", x_decode());
    cyc(6'h02, 6'h00, 0, 0);
    chk("j_jump", e(JUMP, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00,
                    3'b010, 0, 0, 0, 1, 0));

    // addi
    cyc(6'h08, 6'h00, 0, 1);
    chk("addi_fetch", x_fetch(1'b1));
    cyc(6'h08, 6'h00, 0, 0);
    chk("addi_decode", x_decode());
    cyc(6'h08, 6'h00, 0, 0);
    chk("addi_ex", e(ADDIEX, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10,
                     3'b010, 0, 0, 0, 0, 0));
    cyc(6'h3F, 6'h00, 0, 1);
    chk("addi_wb", e(ADDIWB, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00,
                     3'b010, 1, 0, 0, 1, 0));

    // illegal opcode: sticky trap regardless of inputs
    cyc(6'h3F, 6'h00, 0, 1);
    chk("ill_fetch", x_fetch(1'b1));
    cyc(6'h3F, 6'h00, 0, 1);
    chk("ill_decode", x_decode());
    for (int i = 0; i < 11; i++) begin
      cyc(6'(i), 6'h20, i[0], i[1]);
      chk($sformatf("ill_trap%0d", i), x_trap());
    end
    #2;
    rst = 1'b1;
    #1;
    chk("trap_rst_zero", 22'd0);
    @(negedge clk);
    rst = 1'b0;
    opcode = 6'h00;
    funct = 6'h27;
    mem_ready = 1'b1;
    #1;
    chk("trap_rst_fetch", x_fetch(1'b1));

    // illegal funct
    cyc(6'h00, 6'h27, 0, 1);
    chk("fn_decode", x_decode());
    cyc(6'h00, 6'h27, 0, 1);
    chk("fn_exec", x_exec(3'b010));
    for (int i = 0; i < 10; i++) begin
      cyc(6'h23, 6'h20, 1, 1);
      chk($sformatf("fn_trap%0d", i), x_trap());
    end
    #2;
    rst = 1'b1;
    #1;
    chk("fn_rst_zero", 22'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("fn_rst_fetch", x_fetch(1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
